rfsoc_dm_cmd_seq: RTL and testbench

Capture sequencer between the RFSoC register block and one AXI DataMover channel (MM2S for DAC playback, S2MM for ADC capture). On a start edge it latches the programmed start address and byte count, splits the transfer into chunk-sized DataMover commands with bounded outstanding depth, and consumes the status stream. It reports progress, completion, cycle count and errors back to the register block. Two instances are used, one for DAC and one for ADC.

---
 rtl/rfsoc_dm_cmd_seq.sv | 172 +++++++++++++++++
 tb/tb_rfsoc_dm_cmd_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfsoc_dm_cmd_seq.sv
// rfsoc_dm_cmd_seq
// Splits a programmed capture/playback region into chunk-sized AXI DataMover
// commands. It limits how many commands may be in flight, consumes the status
// stream, and reports progress, completion and errors to the register block.
module rfsoc_dm_cmd_seq #(
   parameter int unsigned CHUNK_BYTES     = 32'h0010_0000,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        soft_reset,
   input  logic        start,
   input  logic [31:0] start_addr,
   input  logic [31:0] cap_size,
   output logic        cmd_tvalid,
   input  logic        cmd_tready,
   output logic [71:0] cmd_tdata,
   input  logic        sts_tvalid,
   output logic        sts_tready,
   input  logic [7:0]  sts_tdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        err_sticky,
   output logic [31:0] current_addr,
   output logic [15:0] run_cycles,
   output logic [7:0]  last_status
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   localparam logic [31:0] CHUNK  = 32'(CHUNK_BYTES);
   localparam logic [3:0]  MAX_OS = 4'(MAX_OUTSTANDING);

   state_t      state;
   logic        start_q;
   logic [31:0] remaining;
   logic [3:0]  outstanding;
   logic [3:0]  tag;

   logic        start_rise;
   logic        last_chunk;
   logic        cmd_hs;
   logic        sts_bad;
   logic        first_bad;
   logic [22:0] btt;
   logic [31:0] btt_ext;
   logic [31:0] remaining_next;
   logic [3:0]  outstanding_next;

   assign sts_tready = 1'b1;
   assign start_rise = start & ~start_q;

   // The final chunk is whatever is left once it fits in one command.
   assign last_chunk = (remaining <= CHUNK);
   assign btt        = last_chunk ? remaining[22:0] : CHUNK[22:0];
   assign btt_ext    = {9'd0, btt};

   // Command fields all come from registers, so they hold while stalled.
   assign cmd_tdata  = {4'd0, tag, current_addr, 1'b0, last_chunk, 6'd0, 1'b1, btt};

   // soft_reset also resets the DataMover, so valid may drop at once.
   assign cmd_tvalid = (state == ISSUE) && (remaining != 32'd0) &&
                       (outstanding < MAX_OS) && !soft_reset;
   assign cmd_hs     = cmd_tvalid & cmd_tready;

   assign remaining_next = cmd_hs ? (remaining - btt_ext) : remaining;

   // Bad when OKAY is clear or any of SLVERR/DECERR/INTERR is set.
   assign sts_bad   = ~sts_tdata[7] | (|sts_tdata[6:4]);
   assign first_bad = sts_tvalid & sts_bad & busy & ~err_sticky;

   // In-flight count: accept and status together cancel; never underflow.
   always_comb begin
      outstanding_next = outstanding;
      if (cmd_hs && !sts_tvalid) begin
         outstanding_next = outstanding + 4'd1;
      end else if (!cmd_hs && sts_tvalid && outstanding != 4'd0) begin
         outstanding_next = outstanding - 4'd1;
      end
   end

   // Sequencer FSM with all reported status held in registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state        <= IDLE;
         start_q      <= 1'b0;
         remaining    <= 32'd0;
         outstanding  <= 4'd0;
         tag          <= 4'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         err_sticky   <= 1'b0;
         current_addr <= 32'd0;
         run_cycles   <= 16'd0;
         last_status  <= 8'd0;
      end else if (soft_reset) begin
         state        <= IDLE;
         start_q      <= 1'b0;
         remaining    <= 32'd0;
         outstanding  <= 4'd0;
         tag          <= 4'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         err_sticky   <= 1'b0;
         current_addr <= 32'd0;
         run_cycles   <= 16'd0;
         last_status  <= 8'd0;
      end else begin
         start_q     <= start;
         err         <= first_bad;
         outstanding <= outstanding_next;
         if (sts_tvalid) begin
            last_status <= sts_tdata;
         end
         if (first_bad) begin
            err_sticky <= 1'b1;
         end
         if (busy && run_cycles != 16'hFFFF) begin
            run_cycles <= run_cycles + 16'd1;
         end
         if (cmd_hs) begin
            current_addr <= current_addr + btt_ext;
            remaining    <= remaining_next;
            tag          <= tag + 4'd1;
         end
         case (state)
            IDLE: begin
               if (start_rise) begin
                  current_addr <= start_addr;
                  remaining    <= cap_size;
                  tag          <= 4'd0;
                  err_sticky   <= 1'b0;
                  run_cycles   <= 16'd0;
                  if (cap_size != 32'd0) begin
                     state <= ISSUE;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (first_bad || (cmd_hs && remaining_next == 32'd0)) begin
                  if (outstanding_next == 4'd0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (outstanding_next == 4'd0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rfsoc_dm_cmd_seq.sv
// Testbench for rfsoc_dm_cmd_seq: table-driven runs, hand-written corner
// sequences and randomized runs against a chunk-count reference model.
module tb_rfsoc_dm_cmd_seq;

   localparam int unsigned CHUNK = 32'h0010_0000;
   localparam int          MAXOS = 4;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic        soft_reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] start_addr = 32'd0;
   logic [31:0] cap_size = 32'd0;
   logic        cmd_tvalid;
   logic        cmd_tready = 1'b0;
   logic [71:0] cmd_tdata;
   logic        sts_tvalid = 1'b0;
   logic        sts_tready;
   logic [7:0]  sts_tdata = 8'd0;
   logic        busy, done, err, err_sticky;
   logic [31:0] current_addr;
   logic [15:0] run_cycles;
   logic [7:0]  last_status;

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  model_last = 8'd0;

   always #5 clk = ~clk;

   rfsoc_dm_cmd_seq #(
      .CHUNK_BYTES(CHUNK),
      .MAX_OUTSTANDING(MAXOS)
   ) dut (
      .clk(clk), .rstb(rstb), .soft_reset(soft_reset), .start(start),
      .start_addr(start_addr), .cap_size(cap_size),
      .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_tdata(cmd_tdata),
      .sts_tvalid(sts_tvalid), .sts_tready(sts_tready), .sts_tdata(sts_tdata),
      .busy(busy), .done(done), .err(err), .err_sticky(err_sticky),
      .current_addr(current_addr), .run_cycles(run_cycles), .last_status(last_status)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected command for chunk idx of a region, straight from the field list.
   function automatic logic [71:0] exp_cmd(input logic [31:0] addr, input logic [31:0] size,
                                           input int idx);
      logic [31:0] off, rem, b;
      logic [3:0]  t;
      logic        eof;
      off = 32'(longint'(idx) * longint'(CHUNK));
      rem = size - off;
      b   = (rem < CHUNK) ? rem : CHUNK;
      eof = (rem <= CHUNK);
      t   = 4'(idx % 16);
      return {4'h0, t, addr + off, 1'b0, eof, 6'h00, 1'b1, b[22:0]};
   endfunction

   // One complete run with random backpressure and status return. Model state
   // is just: chunks issued, statuses returned, error seen.
   task automatic run(input logic [31:0] addr, input logic [31:0] size, input int bad_idx,
                      input logic [7:0] bad_val, input int rdy_pct, input int sts_pct,
                      output int issued, output bit errseen);
      int  n, returned, busy_cycles;
      bit  errpulse, term, fin, hs, sv;
      logic [31:0] exp_addr;
      n = int'((longint'(size) + longint'(CHUNK) - 1) / longint'(CHUNK));
      issued = 0; returned = 0; busy_cycles = 0; errseen = 0; errpulse = 0; fin = 0;
      start_addr = addr; cap_size = size; start = 1'b1;
      tick;
      for (int c = 0; c < 3000; c++) begin
         term = (issued == n) || errseen;
         fin  = term && (returned == issued);
         check("busy", busy, !fin);
         check("done", done, fin);
         check("err_pulse", err, errpulse);
         check("cmd_tvalid", cmd_tvalid, !term && ((issued - returned) < MAXOS));
         if (cmd_tvalid) check("cmd_tdata", cmd_tdata, exp_cmd(addr, size, issued));
         if (fin) break;
         busy_cycles++;
         cmd_tready = ($urandom_range(99) < rdy_pct);
         sv = (returned < issued) && ($urandom_range(99) < sts_pct);
         sts_tvalid = sv;
         sts_tdata  = (returned == bad_idx) ? bad_val : (8'h80 | 8'(returned % 16));
         hs = cmd_tvalid && cmd_tready;
         tick;
         errpulse = 0;
         if (hs) issued++;
         if (sv) begin
            if (returned == bad_idx && !errseen) begin
               errseen  = 1;
               errpulse = 1;
            end
            model_last = sts_tdata;
            returned++;
         end
      end
      check("run_timeout", fin, 1'b1);
      cmd_tready = 1'b0;
      sts_tvalid = 1'b0;
      exp_addr = (issued == n) ? addr + size : addr + 32'(longint'(issued) * longint'(CHUNK));
      check("current_addr", current_addr, exp_addr);
      check("err_sticky", err_sticky, errseen);
      check("run_cycles", run_cycles, 16'(busy_cycles));
      check("last_status", last_status, model_last);
      // start stays high: no retrigger, done stays set
      for (int i = 0; i < 20; i++) begin
         tick;
         check("hold_busy", busy, 1'b0);
         check("hold_done", done, 1'b1);
         check("hold_valid", cmd_tvalid, 1'b0);
      end
      start = 1'b0;
      tick;
      $display("[TB] run addr=%h size=%h cmds=%0d err=%0b cycles=%0d",
               addr, size, issued, errseen, busy_cycles);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] size;
      int          bad_idx;
      logic [7:0]  bad_val;
      int          rdy_pct;
      int          sts_pct;
      int          exp_cmds;   // -1: timing dependent, not checked
      logic [31:0] exp_addr;
      bit          exp_err;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int          issued, cnt;
      bit          es;
      logic [31:0] a, s;
      logic [7:0]  bads[5];

      vecs[0] = '{32'h8000_0000, 32'h0030_0000, -1, 8'h00, 100, 100, 3, 32'h8030_0000, 1'b0};
      vecs[1] = '{32'h8000_0000, 32'h0010_0040, -1, 8'h00,  70,  60, 2, 32'h8010_0040, 1'b0};
      vecs[2] = '{32'h1000_0000, 32'h0040_0000,  1, 8'h41, 100,  40, -1, 32'h0, 1'b1};
      vecs[3] = '{32'h4000_0000, 32'h0000_0000, -1, 8'h00, 100, 100, 0, 32'h4000_0000, 1'b0};
      vecs[4] = '{32'hFFF0_0000, 32'h0020_0000, -1, 8'h00,  80,  80, 2, 32'h0010_0000, 1'b0};
      vecs[5] = '{32'h0000_0000, 32'h0140_0005, -1, 8'h00,  90,  50, 21, 32'h0140_0005, 1'b0};
      bads[0] = 8'h00; bads[1] = 8'h41; bads[2] = 8'h90; bads[3] = 8'hA0; bads[4] = 8'hC0;

      // reset state
      tick; tick;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_err_sticky", err_sticky, 1'b0);
      check("rst_valid", cmd_tvalid, 1'b0);
      check("rst_addr", current_addr, 32'd0);
      check("rst_cycles", run_cycles, 16'd0);
      check("rst_last", last_status, 8'd0);
      check("rst_sts_tready", sts_tready, 1'b1);
      rstb = 1'b1;
      tick;

      // table-driven runs
      foreach (vecs[i]) begin
         run(vecs[i].addr, vecs[i].size, vecs[i].bad_idx, vecs[i].bad_val,
             vecs[i].rdy_pct, vecs[i].sts_pct, issued, es);
         if (vecs[i].exp_cmds >= 0) begin
            check("tbl_cmds", issued, vecs[i].exp_cmds);
            check("tbl_addr", current_addr, vecs[i].exp_addr);
         end
         check("tbl_err_sticky", err_sticky, vecs[i].exp_err);
      end

      // backpressure stability, outstanding limit, release by one status
      start_addr = 32'h2000_0000; cap_size = 32'h0080_0000; start = 1'b1; cmd_tready = 1'b0;
      tick;
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", cmd_tvalid, 1'b1);
         check("bp_data", cmd_tdata, exp_cmd(32'h2000_0000, 32'h0080_0000, 0));
         tick;
      end
      cmd_tready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (cmd_tvalid) cnt++;
         tick;
      end
      check("limit_cmds", cnt, 4);
      check("limit_valid", cmd_tvalid, 1'b0);
      sts_tvalid = 1'b1; sts_tdata = 8'h80;
      tick;
      sts_tvalid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (cmd_tvalid) begin
            cnt++;
            check("release_data", cmd_tdata, exp_cmd(32'h2000_0000, 32'h0080_0000, 4));
         end
         tick;
      end
      check("release_cmds", cnt, 1);
      cmd_tready = 1'b0; start = 1'b0; soft_reset = 1'b1;
      tick;
      soft_reset = 1'b0;
      tick;
      $display("[TB] backpressure/limit sequence done");

      // soft_reset with two commands outstanding
      start_addr = 32'h3000_0000; cap_size = 32'h0040_0000; start = 1'b1; cmd_tready = 1'b1;
      tick;
      tick; tick;
      cmd_tready = 1'b0;
      check("sr_pre_addr", current_addr, 32'h3020_0000);
      soft_reset = 1'b1;
      #1;
      check("sr_valid_now", cmd_tvalid, 1'b0);
      tick;
      check("sr_busy", busy, 1'b0);
      check("sr_valid", cmd_tvalid, 1'b0);
      check("sr_done", done, 1'b0);
      check("sr_addr", current_addr, 32'd0);
      check("sr_last", last_status, 8'd0);
      soft_reset = 1'b0; start = 1'b0; model_last = 8'd0;
      tick;
      $display("[TB] soft_reset sequence done");

      // status absorbed in IDLE: no error, no underflow
      sts_tvalid = 1'b1; sts_tdata = 8'h55;
      tick;
      sts_tvalid = 1'b0; model_last = 8'h55;
      check("idle_sts_last", last_status, 8'h55);
      check("idle_sts_err", err, 1'b0);
      check("idle_sts_sticky", err_sticky, 1'b0);
      check("idle_sts_busy", busy, 1'b0);
      $display("[TB] idle status absorb done");
      run(32'h5000_0000, 32'h0020_0000, -1, 8'h00, 100, 100, issued, es);
      check("after_sr_cmds", issued, 2);

      // randomized runs
      for (int r = 0; r < 30; r++) begin
         a = $urandom;
         if (r % 5 == 0) a = 32'hFFE0_0000 + 32'($urandom_range(0, 255));
         s = 32'($urandom_range(0, 12)) * CHUNK;
         if ($urandom_range(0, 1) == 1) s = s + 32'($urandom_range(1, CHUNK - 1));
         run(a, s, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1,
             bads[$urandom_range(0, 4)], int'($urandom_range(30, 100)),
             int'($urandom_range(20, 100)), issued, es);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
